// File: rtl/regwrite_sequencer.sv
// Write-back sequencer for the multicycle MIPS core: picks register-file write selects,
// waits for memory or mult/div results, then issues a single write strobe and a done pulse.
module regwrite_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int DM_TIMEOUT  = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   input  logic       divmul_done,
   output logic [1:0] wr_reg_sel,
   output logic [1:0] wb_data_sel,
   output logic       reg_write,
   output logic       hilo_write,
   output logic       busy,
   output logic       done,
   output logic       timeout_err
);

   localparam int MAX_TO = (MEM_TIMEOUT > DM_TIMEOUT) ? MEM_TIMEOUT : DM_TIMEOUT;
   localparam int CW     = $clog2(MAX_TO + 1);
   localparam logic [CW-1:0] MEM_LIMIT = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0] DM_LIMIT  = CW'(DM_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT_MEM,
      WAIT_DM,
      HILO,
      DONE,
      ERR
   } state_t;

   state_t        state, next_state;
   logic [CW-1:0] count, next_count;
   logic [1:0]    next_wr_sel, next_data_sel;

   // Next-state, counter and select decode; selects only change on an accepted start
   always_comb begin
      next_state    = state;
      next_count    = count;
      next_wr_sel   = wr_reg_sel;
      next_data_sel = wb_data_sel;
      case (state)
         IDLE: begin
            if (start) begin
               next_count = '0;
               next_state = DONE;
               if (opcode == 6'h00) begin
                  case (funct)
                     6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h02, 6'h03: begin
                        next_wr_sel   = 2'b11;
                        next_data_sel = 2'b00;
                        next_state    = WRITE;
                     end
                     6'h10, 6'h12: begin
                        next_wr_sel   = 2'b11;
                        next_data_sel = 2'b11;
                        next_state    = WRITE;
                     end
                     6'h18, 6'h1A: next_state = WAIT_DM;
                     default:      next_state = DONE;
                  endcase
               end else begin
                  case (opcode)
                     6'h08, 6'h09, 6'h0A, 6'h0F: begin
                        next_wr_sel   = 2'b10;
                        next_data_sel = 2'b00;
                        next_state    = WRITE;
                     end
                     6'h20, 6'h21, 6'h23: begin
                        next_wr_sel   = 2'b10;
                        next_data_sel = 2'b01;
                        next_state    = WAIT_MEM;
                     end
                     6'h03: begin
                        next_wr_sel   = 2'b01;
                        next_data_sel = 2'b10;
                        next_state    = WRITE;
                     end
                     default: next_state = DONE;
                  endcase
               end
            end
         end
         WRITE: next_state = DONE;
         // A ready arriving on the limit edge still wins over the timeout
         WAIT_MEM: begin
            if (mem_ready)               next_state = WRITE;
            else if (count == MEM_LIMIT) next_state = ERR;
            next_count = (count == CNT_MAX) ? count : count + CW'(1);
         end
         WAIT_DM: begin
            if (divmul_done)            next_state = HILO;
            else if (count == DM_LIMIT) next_state = ERR;
            next_count = (count == CNT_MAX) ? count : count + CW'(1);
         end
         HILO:    next_state = DONE;
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         wr_reg_sel  <= 2'b10;
         wb_data_sel <= 2'b00;
         reg_write   <= 1'b0;
         hilo_write  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= next_state;
         count       <= next_count;
         wr_reg_sel  <= next_wr_sel;
         wb_data_sel <= next_data_sel;
         reg_write   <= (next_state == WRITE);
         hilo_write  <= (next_state == HILO);
         busy        <= (next_state != IDLE);
         done        <= (next_state == DONE) || (next_state == ERR);
         timeout_err <= (next_state == ERR);
      end
   end

endmodule

// File: tb/tb_regwrite_sequencer.sv
// Directed bench for regwrite_sequencer: inline latency checks plus a scoreboard of
// expected strobe/select/error results compared at every done pulse.
module tb_regwrite_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       mem_ready = 1'b0;
   logic       divmul_done = 1'b0;
   logic [1:0] wr_reg_sel, wb_data_sel;
   logic       reg_write, hilo_write, busy, done, timeout_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         kind;
      logic [1:0] sel;
      logic [1:0] data;
      logic       terr;
   } exp_t;

   exp_t sb[$];
   int         seen_reg = 0;
   int         seen_hilo = 0;
   logic [1:0] strobe_sel = '0;
   logic [1:0] strobe_data = '0;
   int         wait_cycles;

   regwrite_sequencer #(.MEM_TIMEOUT(15), .DM_TIMEOUT(40)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .opcode(opcode),
      .funct(funct),
      .mem_ready(mem_ready),
      .divmul_done(divmul_done),
      .wr_reg_sel(wr_reg_sel),
      .wb_data_sel(wb_data_sel),
      .reg_write(reg_write),
      .hilo_write(hilo_write),
      .busy(busy),
      .done(done),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start across one rising edge; returns at the negedge of the first cycle after it
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
      @(negedge clk);
      start  = 1'b1;
      opcode = op;
      funct  = fn;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_exp(input int kind, input logic [1:0] sel, input logic [1:0] data,
                           input logic terr);
      exp_t e;
      e.kind = kind;
      e.sel  = sel;
      e.data = data;
      e.terr = terr;
      sb.push_back(e);
   endtask

   // Monitor: accumulate strobes between done pulses and compare them against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         seen_reg  = 0;
         seen_hilo = 0;
      end else begin
         if (reg_write) begin
            seen_reg++;
            strobe_sel  = wr_reg_sel;
            strobe_data = wb_data_sel;
            checkOutput("strobe_exclusive", {7'd0, hilo_write}, 8'd0);
         end
         if (hilo_write) seen_hilo++;
         if (done) begin
            checkOutput("sb_has_entry_at_done", {7'd0, sb.size() != 0}, 8'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("sb_reg_write_count", 8'(seen_reg), (e.kind == 1) ? 8'd1 : 8'd0);
               checkOutput("sb_hilo_write_count", 8'(seen_hilo), (e.kind == 2) ? 8'd1 : 8'd0);
               checkOutput("sb_timeout_err", {7'd0, timeout_err}, {7'd0, e.terr});
               if (e.kind == 1) begin
                  checkOutput("sb_strobe_wr_sel", {6'd0, strobe_sel}, {6'd0, e.sel});
                  checkOutput("sb_strobe_data_sel", {6'd0, strobe_data}, {6'd0, e.data});
               end
            end
            seen_reg  = 0;
            seen_hilo = 0;
         end
      end
   end

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_wr_sel"}, {6'd0, wr_reg_sel}, 8'h02);
      checkOutput({tag, "_data_sel"}, {6'd0, wb_data_sel}, 8'h00);
      checkOutput({tag, "_reg_write"}, {7'd0, reg_write}, 8'd0);
      checkOutput({tag, "_hilo_write"}, {7'd0, hilo_write}, 8'd0);
      checkOutput({tag, "_busy"}, {7'd0, busy}, 8'd0);
      checkOutput({tag, "_done"}, {7'd0, done}, 8'd0);
      checkOutput({tag, "_timeout_err"}, {7'd0, timeout_err}, 8'd0);
   endtask

   initial begin
      // Reset values
      #12;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("post_reset");

      // add: reg_write at k+1, done at k+2, idle at k+3
      push_exp(1, 2'b11, 2'b00, 1'b0);
      applyStimulus(6'h00, 6'h20);
      checkOutput("add_reg_write", {7'd0, reg_write}, 8'd1);
      checkOutput("add_wr_sel", {6'd0, wr_reg_sel}, 8'h03);
      checkOutput("add_data_sel", {6'd0, wb_data_sel}, 8'h00);
      checkOutput("add_busy_k1", {7'd0, busy}, 8'd1);
      @(negedge clk);
      checkOutput("add_done", {7'd0, done}, 8'd1);
      checkOutput("add_reg_write_off", {7'd0, reg_write}, 8'd0);
      checkOutput("add_busy_k2", {7'd0, busy}, 8'd1);
      @(negedge clk);
      checkOutput("add_busy_k3", {7'd0, busy}, 8'd0);
      checkOutput("add_done_off", {7'd0, done}, 8'd0);
      checkOutput("add_sel_held_idle", {6'd0, wr_reg_sel}, 8'h03);

      // lw with mem_ready a few cycles after start
      push_exp(1, 2'b10, 2'b01, 1'b0);
      applyStimulus(6'h23, 6'h00);
      for (int i = 0; i < 3; i++) begin
         checkOutput("lw_wait_wr_sel", {6'd0, wr_reg_sel}, 8'h02);
         checkOutput("lw_wait_data_sel", {6'd0, wb_data_sel}, 8'h01);
         checkOutput("lw_wait_no_write", {7'd0, reg_write}, 8'd0);
         @(negedge clk);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("lw_reg_write", {7'd0, reg_write}, 8'd1);
      @(negedge clk);
      checkOutput("lw_done", {7'd0, done}, 8'd1);
      checkOutput("lw_timeout_err", {7'd0, timeout_err}, 8'd0);
      @(negedge clk);

      // jal then jr
      push_exp(1, 2'b01, 2'b10, 1'b0);
      applyStimulus(6'h03, 6'h00);
      checkOutput("jal_reg_write", {7'd0, reg_write}, 8'd1);
      checkOutput("jal_wr_sel", {6'd0, wr_reg_sel}, 8'h01);
      checkOutput("jal_data_sel", {6'd0, wb_data_sel}, 8'h02);
      @(negedge clk);
      @(negedge clk);
      push_exp(0, 2'b00, 2'b00, 1'b0);
      applyStimulus(6'h00, 6'h08);
      checkOutput("jr_done_k1", {7'd0, done}, 8'd1);
      checkOutput("jr_no_write", {7'd0, reg_write}, 8'd0);
      @(negedge clk);
      checkOutput("jr_idle", {7'd0, busy}, 8'd0);

      // mult with no divmul_done: timeout after 40 WAIT_DM cycles
      push_exp(0, 2'b00, 2'b00, 1'b1);
      applyStimulus(6'h00, 6'h18);
      wait_cycles = 1;
      while (!done && wait_cycles < 60) begin
         @(negedge clk);
         wait_cycles++;
      end
      checkOutput("mult_timeout_cycle", 8'(wait_cycles), 8'd41);
      checkOutput("mult_timeout_err", {7'd0, timeout_err}, 8'd1);
      @(negedge clk);

      // div with divmul_done: hilo_write then done
      push_exp(2, 2'b00, 2'b00, 1'b0);
      applyStimulus(6'h00, 6'h1A);
      @(negedge clk);
      divmul_done = 1'b1;
      @(negedge clk);
      divmul_done = 1'b0;
      checkOutput("div_hilo_write", {7'd0, hilo_write}, 8'd1);
      checkOutput("div_no_reg_write", {7'd0, reg_write}, 8'd0);
      @(negedge clk);
      checkOutput("div_done", {7'd0, done}, 8'd1);
      @(negedge clk);

      // lw with mem_ready on the limit edge, plus an ignored start while busy
      push_exp(1, 2'b10, 2'b01, 1'b0);
      applyStimulus(6'h23, 6'h00);
      for (int i = 0; i < 14; i++) begin
         if (i == 3) begin
            start  = 1'b1;
            opcode = 6'h00;
            funct  = 6'h20;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("limit_still_waiting", {7'd0, done}, 8'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("limit_reg_write", {7'd0, reg_write}, 8'd1);
      checkOutput("limit_sel_unchanged", {6'd0, wr_reg_sel}, 8'h02);
      @(negedge clk);
      checkOutput("limit_done", {7'd0, done}, 8'd1);
      checkOutput("limit_timeout_err", {7'd0, timeout_err}, 8'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("limit_single_done", {7'd0, done}, 8'd0);
      checkOutput("limit_idle", {7'd0, busy}, 8'd0);

      // Reset during WAIT_MEM aborts the load
      applyStimulus(6'h23, 6'h00);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_values("async_reset");
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("post_abort_no_write", {7'd0, reg_write}, 8'd0);
      @(negedge clk);
      checkOutput("post_abort_no_done", {7'd0, done}, 8'd0);

      // Fresh addi after reset
      push_exp(1, 2'b10, 2'b00, 1'b0);
      applyStimulus(6'h08, 6'h00);
      checkOutput("addi_reg_write", {7'd0, reg_write}, 8'd1);
      checkOutput("addi_wr_sel", {6'd0, wr_reg_sel}, 8'h02);
      @(negedge clk);
      checkOutput("addi_done", {7'd0, done}, 8'd1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("sb_empty_at_end", 8'(sb.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
